// File: rtl/seg_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// seg_pkg : shared constants for the seven-segment scan logic
// Rev 1.0 : initial release
// ------------------------------------------------------------------
package seg_pkg;
  localparam int DIGIT_W        = 4;
  localparam int NUM_DIGITS_DEF = 8;
  localparam int SCAN_DIV_DEF   = 100000;
  localparam int SIM_SCAN_DIV   = 4;
endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ------------------------------------------------------------------
// seg_scan_driver_if : value load / scan output bundle of the driver
// Rev 1.0 : initial release
// ------------------------------------------------------------------
interface seg_scan_driver_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);
  localparam int AN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] data_in;
  logic                          blank_lz;
  logic [DIGIT_W-1:0]            digit;
  logic [AN_W-1:0]               an;
  logic [NUM_DIGITS-1:0]         an_n;
  logic                          blank;
  logic                          pending;
  logic                          frame;

  modport master (
    output load, data_in, blank_lz,
    input  digit, an, an_n, blank, pending, frame
  );

  modport slave (
    input  load, data_in, blank_lz,
    output digit, an, an_n, blank, pending, frame
  );
endinterface
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// scan_tick_gen : free-running divider, one-cycle tick every DIV clks
// Rev 1.0 : initial release
// ------------------------------------------------------------------
module scan_tick_gen #(
  parameter int DIV = 100000
) (
  input  wire  clk,
  input  wire  rst,
  output logic tick
);
  localparam int             CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ------------------------------------------------------------------
// seg_scan_driver : multiplexed 7-seg digit scanner, frame-buffered
// Rev 1.0 : initial release
// ------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
  input wire               clk,
  input wire               rst,
  seg_scan_driver_if.slave bus
);
  localparam int              AN_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int              DATA_W   = DIGIT_W * NUM_DIGITS;
  localparam logic [AN_W-1:0] LAST_IDX = AN_W'(NUM_DIGITS - 1);

  logic              w_tick;
  logic              w_boundary;
  logic [AN_W-1:0]   r_idx;
  logic [DATA_W-1:0] r_disp;
  logic [DATA_W-1:0] r_pend;
  logic              r_pend_valid;
  logic              r_frame;
  logic [AN_W-1:0]   w_msd;
  logic              w_blank;

  scan_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_boundary = w_tick && (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_frame      <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      if (w_tick) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_boundary && r_pend_valid) begin
        r_disp       <= r_pend;
        r_pend_valid <= 1'b0;
      end
      // A load on the boundary cycle lands after the transfer and stays pending
      if (bus.load) begin
        r_pend       <= bus.data_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Highest nonzero digit of the displayed value; 0 when the value is 0
  always_comb begin
    w_msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (r_disp[DIGIT_W*k +: DIGIT_W] != '0) begin
        w_msd = AN_W'(k);
      end
    end
  end

  assign w_blank     = bus.blank_lz && (r_idx > w_msd);
  assign bus.digit   = r_disp[DIGIT_W*r_idx +: DIGIT_W];
  assign bus.an      = r_idx;
  assign bus.an_n    = w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
  assign bus.blank   = w_blank;
  assign bus.pending = r_pend_valid;
  assign bus.frame   = r_frame;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_seg_scan_driver : directed self-checking bench for seg_scan_driver
// Rev 1.0 : initial release
// ------------------------------------------------------------------
module tb_seg_scan_driver;
  import seg_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_scan_driver_if #(.NUM_DIGITS(8)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS (8),
    .SCAN_DIV   (SIM_SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_val(input logic [31:0] v);
    bus.load    = 1'b1;
    bus.data_in = v;
    step(1);
    bus.load    = 1'b0;
  endtask

  // Advance at least one cycle, then until frame pulses (bounded)
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.frame && n < 200);
    check("frame_timeout", 32'(bus.frame), 32'd1);
  endtask

  initial begin
    logic [31:0]     val;
    logic [3:0]      exp_a05 [8];
    int              n;
    int              nonzero;
    checks = 0;
    errors = 0;
    exp_a05 = '{4'h5, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    // 1. reset with load asserted
    rst = 1'b1;
    bus.load = 1'b1;
    bus.data_in = 32'hFFFF_FFFF;
    bus.blank_lz = 1'b0;
    step(3);
    rst = 1'b0;
    bus.load = 1'b0;
    check("rst_digit",   32'(bus.digit),   32'h0);
    check("rst_an",      32'(bus.an),      32'h0);
    check("rst_an_n",    32'(bus.an_n),    32'hFE);
    check("rst_blank",   32'(bus.blank),   32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_frame",   32'(bus.frame),   32'h0);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.frame && n < 100);
    check("first_frame_cycles", 32'(n), 32'd32);

    // 2. single load, then one full frame of scanning
    load_val(32'h1234_5678);
    check("load_pending", 32'(bus.pending), 32'h1);
    wait_frame();
    check("xfer_pending", 32'(bus.pending), 32'h0);
    val = 32'h1234_5678;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        check("scan_digit", 32'(bus.digit), (val >> (4*d)) & 32'hF);
        check("scan_an",    32'(bus.an),    32'(d));
        check("scan_an_n",  32'(bus.an_n),  ~(32'h1 << d) & 32'hFF);
        check("scan_frame", 32'(bus.frame), 32'((d == 0) && (c == 0)));
        step(1);
      end
    end

    // 3a. two loads in one frame: last wins
    load_val(32'hAAAA_AAAA);
    step(1);
    load_val(32'h5555_5555);
    wait_frame();
    for (int d = 0; d < 8; d++) begin
      check("dbl_digit", 32'(bus.digit), 32'h5);
      step(4);
    end

    // 3b. load on the boundary cycle
    check("coll_at_frame", 32'(bus.frame), 32'h1);
    load_val(32'h3333_3333);
    step(30);
    check("coll_pre_an", 32'(bus.an), 32'd7);
    load_val(32'h9999_9999);
    check("coll_frame",   32'(bus.frame),   32'h1);
    check("coll_digit",   32'(bus.digit),   32'h3);
    check("coll_pending", 32'(bus.pending), 32'h1);
    wait_frame();
    check("coll_next_digit",   32'(bus.digit),   32'h9);
    check("coll_next_pending", 32'(bus.pending), 32'h0);

    // 4. leading-zero blanking
    bus.blank_lz = 1'b1;
    load_val(32'h0000_0A05);
    wait_frame();
    for (int d = 0; d < 8; d++) begin
      check("lz_digit", 32'(bus.digit), 32'(exp_a05[d]));
      check("lz_blank", 32'(bus.blank), 32'(d > 2));
      check("lz_an_n",  32'(bus.an_n),  (d > 2) ? 32'hFF : (~(32'h1 << d) & 32'hFF));
      step(4);
    end

    // 5. zero value with blanking, then release blanking
    load_val(32'h0);
    wait_frame();
    check("zero_d0_digit", 32'(bus.digit), 32'h0);
    check("zero_d0_blank", 32'(bus.blank), 32'h0);
    check("zero_d0_an_n",  32'(bus.an_n),  32'hFE);
    for (int d = 1; d < 8; d++) begin
      step(4);
      check("zero_blank", 32'(bus.blank), 32'h1);
      check("zero_an_n",  32'(bus.an_n),  32'hFF);
    end
    bus.blank_lz = 1'b0;
    step(1);
    check("unblank_blank", 32'(bus.blank), 32'h0);
    check("unblank_an_n",  32'(bus.an_n),  32'h7F);

    // 6. reset mid-frame with a value pending
    wait_frame();
    load_val(32'hBBBB_BBBB);
    step(19);
    check("mid_an",      32'(bus.an),      32'd5);
    check("mid_pending", 32'(bus.pending), 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_an",      32'(bus.an),      32'h0);
    check("mid_rst_pending", 32'(bus.pending), 32'h0);
    check("mid_rst_digit",   32'(bus.digit),   32'h0);
    check("mid_rst_an_n",    32'(bus.an_n),    32'hFE);
    nonzero = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (bus.digit != 4'h0) nonzero++;
    end
    check("mid_never_shown", 32'(nonzero), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
